// File: rtl/debounce_multi.sv
// debounce_multi: parametrised multi-channel switch/contact debouncer.
// Each channel has a 2-flop synchroniser, a private counter and a registered
// debounced level. It also produces registered one-cycle rise/fall pulses.
// MODE 0 (lockout): the output follows the first edge, then the input is
// ignored for BOUNCE_LIMIT cycles.
// MODE 1 (integrate): the output changes only after the input has held the
// new level for BOUNCE_LIMIT consecutive cycles.
module debounce_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned COUNT_WIDTH  = 19,
  parameter int unsigned BOUNCE_LIMIT = 262143,
  parameter int unsigned MODE         = 0,
  parameter bit          INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] switch_in,
  output logic [CHANNELS-1:0] switch_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_LIMIT = COUNT_WIDTH'(BOUNCE_LIMIT);
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST  = COUNT_WIDTH'(BOUNCE_LIMIT - 1);
  localparam logic [CHANNELS-1:0]    LVL_INIT  = {CHANNELS{INIT_LEVEL}};

  // Reject parameter sets the counters cannot represent.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be at least 1");
  end
  if (BOUNCE_LIMIT < 1 ||
      64'(BOUNCE_LIMIT) > ((64'd1 << COUNT_WIDTH) - 64'd1)) begin : g_bad_limit
    $error("debounce_multi: BOUNCE_LIMIT must be in 1 .. 2**COUNT_WIDTH-1");
  end
  if (MODE > 1) begin : g_bad_mode
    $error("debounce_multi: MODE must be 0 (lockout) or 1 (integrate)");
  end

  // Synchroniser stages; sync2_q is the only view of the input any decision uses.
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  // Debounced level and its registered edge pulses.
  logic [CHANNELS-1:0] out_q,  out_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  // Private counter per channel: lockout remaining (MODE 0) or stable run length (MODE 1).
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];

  // Synchroniser shift: raw pin into stage 1, stage 1 into stage 2.
  always_comb begin
    sync1_d = switch_in;
    sync2_d = sync1_q;
  end

  // Per-channel filter decision. Channels share nothing and have no priority order.
  always_comb begin
    // NOTE: every *_d gets its hold/idle value before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (MODE == 0) begin
        // Lockout: accept a difference only when idle, then count down to zero.
        if (cnt_q[i] == CNT_ZERO) begin
          if (sync2_q[i] != out_q[i]) begin
            out_d[i]  = sync2_q[i];
            cnt_d[i]  = CNT_LIMIT;
            rise_d[i] = sync2_q[i];
            fall_d[i] = ~sync2_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end else begin
        // Integrate: any cycle of agreement restarts the run from zero.
        if (sync2_q[i] == out_q[i]) begin
          cnt_d[i] = CNT_ZERO;
        end else if (cnt_q[i] == CNT_LAST) begin
          out_d[i]  = sync2_q[i];
          cnt_d[i]  = CNT_ZERO;
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // State registers. Reset asserts asynchronously. Release is re-timed by the system reset
  // generator, so no pulse is created by release itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= LVL_INIT;
      sync2_q <= LVL_INIT;
      out_q   <= LVL_INIT;
      rise_q  <= '0;
      fall_q  <= '0;
      // NOTE: the counter array is a bank of flops, not a RAM. Resetting it is what
      // aborts an in-progress count, so it must be cleared here.
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order; the synchroniser chain depends on it.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Outputs come straight from registers; switch_in has no combinational path out.
  assign switch_out = out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi.
// d0 runs MODE 0 (lockout) and d1 runs MODE 1 (integrate), both with INIT_LEVEL 0.
// d2 runs MODE 0 with INIT_LEVEL 1.
// All instances use BOUNCE_LIMIT=4 and CHANNELS=4.
// Inputs change 1 time unit after a rising edge. Outputs are read 1 time unit after
// the edge. "Edge k" means the k-th rising edge after the input change.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in0, in1, in2;
  logic [3:0] out0, rise0, fall0;
  logic [3:0] out1, rise1, fall1;
  logic [3:0] out2, rise2, fall2;
  logic       any0, any1, any2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(4), .COUNT_WIDTH(19), .BOUNCE_LIMIT(4), .MODE(0), .INIT_LEVEL(1'b0)) d0 (
    .clk(clk), .reset(reset), .switch_in(in0), .switch_out(out0),
    .rise_pulse(rise0), .fall_pulse(fall0), .any_change(any0));

  debounce_multi #(.CHANNELS(4), .COUNT_WIDTH(19), .BOUNCE_LIMIT(4), .MODE(1), .INIT_LEVEL(1'b0)) d1 (
    .clk(clk), .reset(reset), .switch_in(in1), .switch_out(out1),
    .rise_pulse(rise1), .fall_pulse(fall1), .any_change(any1));

  debounce_multi #(.CHANNELS(4), .COUNT_WIDTH(19), .BOUNCE_LIMIT(4), .MODE(0), .INIT_LEVEL(1'b1)) d2 (
    .clk(clk), .reset(reset), .switch_in(in2), .switch_out(out2),
    .rise_pulse(rise2), .fall_pulse(fall2), .any_change(any2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs held at INIT_LEVEL during reset. After release, all four MODE 0 channels
  // rise together on edge 3. Nothing pulses on the release edge itself.
  task automatic test_reset();
    logic [3:0] er;
    logic [3:0] eo;
    in0 = 4'hF; in1 = 4'h0; in2 = 4'hF;
    #1 reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({out0, rise0, fall0, any0} !== 13'h0) begin
      $display("FAIL reset_d0: got out=%h rise=%h fall=%h any=%b, expected all 0", out0, rise0, fall0, any0);
      miscompares++;
    end
    vectors++;
    if (out2 !== 4'hF || any2 !== 1'b0) begin
      $display("FAIL reset_d2_init: got out=%h any=%b, expected out=f any=0", out2, any2);
      miscompares++;
    end
    vectors++;
    if (out1 !== 4'h0 || any1 !== 1'b0) begin
      $display("FAIL reset_d1: got out=%h any=%b, expected out=0 any=0", out1, any1);
      miscompares++;
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      eo = (k >= 3) ? 4'hF : 4'h0;
      er = (k == 3) ? 4'hF : 4'h0;
      vectors++;
      if (out0 !== eo || rise0 !== er || fall0 !== 4'h0 || any0 !== (k == 3)) begin
        $display("FAIL release_edge%0d: got out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=0 any=%b",
                 k, out0, rise0, fall0, any0, eo, er, (k == 3));
        miscompares++;
      end
      vectors++;
      if (out2 !== 4'hF || any2 !== 1'b0) begin
        $display("FAIL release_d2_edge%0d: got out=%h any=%b, expected out=f any=0", k, out2, any2);
        miscompares++;
      end
    end
  endtask

  // Channel 0 rises and channel 3 falls on the same edge: both pulse together,
  // and any_change is high for that single cycle.
  task automatic test_simultaneous();
    logic [3:0] eo;
    in0 = 4'hE;
    repeat (12) tick();
    vectors++;
    if (out0 !== 4'hE) begin
      $display("FAIL simul_setup: got out=%h, expected e", out0);
      miscompares++;
    end
    in0 = 4'h7;
    for (int k = 1; k <= 4; k++) begin
      tick();
      eo = (k >= 3) ? 4'h7 : 4'hE;
      vectors++;
      if (out0 !== eo || rise0 !== ((k == 3) ? 4'h1 : 4'h0) ||
          fall0 !== ((k == 3) ? 4'h8 : 4'h0) || any0 !== (k == 3)) begin
        $display("FAIL simul_edge%0d: got out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=%h any=%b",
                 k, out0, rise0, fall0, any0, eo, (k == 3) ? 4'h1 : 4'h0, (k == 3) ? 4'h8 : 4'h0, (k == 3));
        miscompares++;
      end
    end
  endtask

  // MODE 0 bounce: ch0 sees 1,0,1,0,1 and then settles at 1. There is a single rise
  // on edge 3, and the following toggles are swallowed by the lockout.
  task automatic test_bounce();
    logic [4:0] seq;
    logic [3:0] eo;
    int rises;
    int falls;
    seq = 5'b10101;  // bit k-1 is the ch0 value present before edge k
    rises = 0;
    falls = 0;
    in0 = 4'h6;
    repeat (12) tick();
    vectors++;
    if (out0 !== 4'h6) begin
      $display("FAIL bounce_setup: got out=%h, expected 6", out0);
      miscompares++;
    end
    for (int k = 1; k <= 12; k++) begin
      in0 = {3'b011, (k <= 5) ? seq[k-1] : 1'b1};
      tick();
      eo = (k >= 3) ? 4'h7 : 4'h6;
      if (rise0[0]) rises++;
      if (fall0[0]) falls++;
      vectors++;
      if (out0 !== eo || rise0 !== ((k == 3) ? 4'h1 : 4'h0) || fall0 !== 4'h0) begin
        $display("FAIL bounce_edge%0d: got out=%h rise=%h fall=%h, expected out=%h rise=%h fall=0",
                 k, out0, rise0, fall0, eo, (k == 3) ? 4'h1 : 4'h0);
        miscompares++;
      end
    end
    vectors++;
    if (rises != 1 || falls != 0) begin
      $display("FAIL bounce_pulse_count: got rises=%0d falls=%0d, expected 1 and 0", rises, falls);
      miscompares++;
    end
  endtask

  // MODE 0 single glitch: a one-cycle low falls on edge 3. The output returns high on
  // edge 8, which is BOUNCE_LIMIT+1 cycles later, when the lockout ends.
  task automatic test_lockout_revert();
    logic eo;
    for (int k = 1; k <= 10; k++) begin
      in0 = {3'b011, (k == 1) ? 1'b0 : 1'b1};
      tick();
      eo = (k < 3 || k >= 8);
      vectors++;
      if (out0[0] !== eo || rise0[0] !== (k == 8) || fall0[0] !== (k == 3)) begin
        $display("FAIL revert_edge%0d: got out0=%b rise0=%b fall0=%b, expected out0=%b rise0=%b fall0=%b",
                 k, out0[0], rise0[0], fall0[0], eo, (k == 8), (k == 3));
        miscompares++;
      end
    end
  endtask

  // MODE 1: 3 high cycles never reach the output. Then 4 high cycles rise on edge 6,
  // and the return low falls on edge 10.
  task automatic test_glitch_reject();
    logic eo;
    in1 = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      in1 = (k <= 3) ? 4'h2 : 4'h0;
      tick();
      vectors++;
      if (out1 !== 4'h0 || rise1 !== 4'h0 || fall1 !== 4'h0) begin
        $display("FAIL glitch3_edge%0d: got out=%h rise=%h fall=%h, expected all 0", k, out1, rise1, fall1);
        miscompares++;
      end
    end
    for (int k = 1; k <= 12; k++) begin
      in1 = (k <= 4) ? 4'h2 : 4'h0;
      tick();
      eo = (k >= 6 && k <= 9);
      vectors++;
      if (out1 !== {2'b00, eo, 1'b0} || rise1 !== ((k == 6) ? 4'h2 : 4'h0) ||
          fall1 !== ((k == 10) ? 4'h2 : 4'h0) || any1 !== (k == 6 || k == 10)) begin
        $display("FAIL integrate4_edge%0d: got out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=%h",
                 k, out1, rise1, fall1, any1, {2'b00, eo, 1'b0},
                 (k == 6) ? 4'h2 : 4'h0, (k == 10) ? 4'h2 : 4'h0);
        miscompares++;
      end
    end
  endtask

  // MODE 1: high 3, low 1, high. The count restarts, so the rise lands 6 edges after
  // the second rising edge (edge 10 overall).
  task automatic test_count_restart();
    logic eo;
    for (int k = 1; k <= 12; k++) begin
      in1 = (k == 4) ? 4'h0 : 4'h4;
      tick();
      eo = (k >= 10);
      vectors++;
      if (out1 !== {1'b0, eo, 2'b00} || rise1 !== ((k == 10) ? 4'h4 : 4'h0) || fall1 !== 4'h0) begin
        $display("FAIL restart_edge%0d: got out=%h rise=%h fall=%h, expected out=%h rise=%h fall=0",
                 k, out1, rise1, fall1, {1'b0, eo, 2'b00}, (k == 10) ? 4'h4 : 4'h0);
        miscompares++;
      end
    end
    in1 = 4'h0;
    repeat (12) tick();
    vectors++;
    if (out1 !== 4'h0) begin
      $display("FAIL restart_settle: got out=%h, expected 0", out1);
      miscompares++;
    end
  endtask

  // MODE 1: a reset mid-count aborts the count without a pulse. After release,
  // the full 2+4 cycle latency applies from the start.
  task automatic test_reset_mid_count();
    logic eo;
    in1 = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (out1 !== 4'h0 || any1 !== 1'b0) begin
        $display("FAIL midcount_pre_edge%0d: got out=%h any=%b, expected 0 and 0", k, out1, any1);
        miscompares++;
      end
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (out1 !== 4'h0 || rise1 !== 4'h0 || any1 !== 1'b0) begin
      $display("FAIL midcount_in_reset: got out=%h rise=%h any=%b, expected all 0", out1, rise1, any1);
      miscompares++;
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      eo = (k >= 6);
      vectors++;
      if (out1 !== {3'b000, eo} || rise1 !== ((k == 6) ? 4'h1 : 4'h0) || any1 !== (k == 6)) begin
        $display("FAIL midcount_post_edge%0d: got out=%h rise=%h any=%b, expected out=%h rise=%h any=%b",
                 k, out1, rise1, any1, {3'b000, eo}, (k == 6) ? 4'h1 : 4'h0, (k == 6));
        miscompares++;
      end
    end
    vectors++;
    if (out2 !== 4'hF || any2 !== 1'b0) begin
      $display("FAIL final_d2: got out=%h any=%b, expected out=f any=0", out2, any2);
      miscompares++;
    end
  endtask

  initial begin
    in0 = 4'h0; in1 = 4'h0; in2 = 4'hF;
    test_reset();
    test_simultaneous();
    test_bounce();
    test_lockout_revert();
    test_glitch_reject();
    test_count_restart();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel switch/contact debouncer.
- Successor to the single-channel robotics-cape debouncer.
- Adds channel count, runtime-independent counter width, selectable filtering mode, reset and registered edge pulses.
- Sits between raw cape switch/encoder-index pins and the robotics register/interrupt logic.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- COUNT_WIDTH, 19: width of each per-channel counter.
- BOUNCE_LIMIT, 262143: filter length in clk cycles. Must satisfy 1 <= BOUNCE_LIMIT <= 2**COUNT_WIDTH-1.
- MODE, 0: filtering mode.
  - 0 = lockout: output follows the first edge immediately, then ignores the input for BOUNCE_LIMIT cycles.
  - 1 = integrate: output changes only after the input has been stable at the new level for BOUNCE_LIMIT consecutive cycles.
- INIT_LEVEL, 0: reset level of synchroniser flops and switch_out (applied to all channels).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- switch_in  input  CHANNELS  raw asynchronous switch inputs.
- switch_out  output  CHANNELS  debounced levels, registered.
- rise_pulse  output  CHANNELS  one-cycle pulse on a 0->1 switch_out transition, registered.
- fall_pulse  output  CHANNELS  one-cycle pulse on a 1->0 switch_out transition, registered.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits (combinational from registers).

Behaviour:
- Reset (async assert, release synchronous to clk):
  - Both synchroniser stages of every channel = INIT_LEVEL.
  - switch_out = {CHANNELS{INIT_LEVEL}}.
  - All counters = 0.
  - rise_pulse = fall_pulse = 0; any_change = 0.
  - No pulse is generated by reset release itself.
  - Reset mid-count aborts the count; no pulse is emitted.
- Synchroniser: 2-flop chain per channel, sync = second stage. All decisions use sync only.
- Channels are fully independent: no shared counters and no priority between channels.
- MODE 0 (lockout), per channel, each clk:
  - If cnt == 0 and sync != switch_out: switch_out <= sync, cnt <= BOUNCE_LIMIT, pulse asserted.
  - If cnt == 0 and sync == switch_out: hold.
  - If cnt != 0: cnt <= cnt-1, switch_out held, input ignored.
  - Latency: input edge to switch_out change = 3 clk edges (2 sync + 1 output).
  - After a transition, the next accepted transition is no earlier than BOUNCE_LIMIT+1 cycles later.
  - If the input is back at the old level when cnt reaches 0, switch_out reverts on that cycle. This is the intended single-glitch response.
- MODE 1 (integrate), per channel, each clk:
  - If sync == switch_out: cnt <= 0.
  - Else if cnt == BOUNCE_LIMIT-1: switch_out <= sync, cnt <= 0, pulse asserted.
  - Else: cnt <= cnt+1.
  - Any single cycle of agreement restarts the count from 0.
  - Latency of a clean edge = 2 + BOUNCE_LIMIT cycles.
  - Pulses shorter than BOUNCE_LIMIT cycles never reach switch_out.
- Pulses:
  - rise_pulse[i]/fall_pulse[i] are high exactly in the cycle where switch_out[i] shows its new value, for one cycle.
  - rise_pulse[i] and fall_pulse[i] are never high simultaneously.
  - Multiple channels may pulse in the same cycle; any_change is high for that single cycle.
- Counter arithmetic:
  - Unsigned COUNT_WIDTH.
  - Never wraps: decrement stops at 0; increment stops at BOUNCE_LIMIT-1.
- No combinational path from switch_in to any output.

Test Plan (BOUNCE_LIMIT=4, CHANNELS=4, INIT_LEVEL=0 unless stated):
- Reset check: reset=1 with switch_in=4'hF, then release -> outputs 0 during reset. After release, MODE 0 ch0..3 rise at cycle 3 with rise_pulse=4'hF for one cycle and any_change=1. No pulse on the release edge itself.
- MODE 0 bounce: ch0 input 0->1, then toggles 1,0,1,0 each cycle for 4 cycles, then settles at 1 -> switch_out[0] rises 3 cycles after the first edge. Input is ignored for 4 cycles, then the output tracks the settled 1. Exactly one rise_pulse and one fall_pulse at most, never both in the same cycle.
- MODE 1 glitch rejection: ch1 high for 3 cycles then low -> switch_out[1] stays 0 and no pulses. Then ch1 high for 4 cycles -> switch_out[1] = 1 at cycle 6 after the edge, with a single rise_pulse[1].
- MODE 1 count restart: ch2 high 3 cycles, low 1 cycle, high 4 cycles -> rise occurs 6 cycles after the second rising edge, not the first.
- Independence/simultaneity: ch0 rises and ch3 falls (from settled 1) on the same edge -> rise_pulse=4'h1 and fall_pulse=4'h8 in the same cycle, any_change=1 for one cycle.
- Reset mid-count: MODE 1, ch0 high 2 cycles, assert reset for 1 cycle, keep input high -> no pulse before reset. After release, a full 2+4 cycle latency applies before the rise.
